// File: rtl/accumulator_unit.sv
// MEH16 accumulator register: loads A, runs INC/DEC/NOT in one cycle and
// shifts/rotates one bit per clock, reporting the carry with a one-cycle done pulse.
module accumulator_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             a_load,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] a_out,
  output logic             a_c_flag,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_SHL = 3'd0;
  localparam logic [2:0] OP_SHR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;
  localparam logic [2:0] OP_INC = 3'd5;
  localparam logic [2:0] OP_DEC = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;
  localparam int         W1     = WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             c_q, c_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] sh_a;
  logic             sh_c;

  // One-bit step of the latched shift/rotate; C takes the bit that falls off.
  always_comb begin
    sh_a = a_q;
    sh_c = c_q;
    case (op_q)
      OP_SHL: begin sh_a = {a_q[WIDTH-2:0], 1'b0};       sh_c = a_q[WIDTH-1]; end
      OP_SHR: begin sh_a = {1'b0, a_q[WIDTH-1:1]};       sh_c = a_q[0];       end
      OP_ASR: begin sh_a = {a_q[WIDTH-1], a_q[WIDTH-1:1]}; sh_c = a_q[0];     end
      OP_ROL: begin sh_a = {a_q[WIDTH-2:0], a_q[WIDTH-1]}; sh_c = a_q[WIDTH-1]; end
      OP_ROR: begin sh_a = {a_q[0], a_q[WIDTH-1:1]};     sh_c = a_q[0];       end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    c_d     = c_q;
    op_d    = op_q;
    rem_d   = rem_q;
    if (state_q == S_SHIFT) begin
      a_d   = sh_a;
      c_d   = sh_c;
      rem_d = rem_q - CNT_W'(1);
      if (rem_q == CNT_W'(1)) state_d = S_DONE;
    end else begin
      state_d = S_IDLE;
      // A load wins over a simultaneous start, and the start is dropped.
      if (a_load) begin
        a_d = data_in;
      end else if (start) begin
        state_d = S_DONE;
        case (op)
          OP_INC: {c_d, a_d} = {1'b0, a_q} + W1'(1);
          OP_DEC: begin a_d = a_q - WIDTH'(1); c_d = (a_q == '0); end
          OP_NOT: a_d = ~a_q;
          default: begin
            if (count != '0) begin
              op_d    = op;
              rem_d   = count;
              state_d = S_SHIFT;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      c_q     <= 1'b0;
      op_q    <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      c_q     <= c_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
    end
  end

  assign a_out    = a_q;
  assign a_c_flag = c_q;
  assign busy     = (state_q == S_SHIFT);
  assign done     = (state_q == S_DONE);

endmodule
